// File: rtl/q_pkg.sv
// Shared types and width helpers for the q_pipe arithmetic pipeline.
package q_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_SHIFT      = 1;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } q_state_t;

  // Internal width wide enough that (a-b)*(1+3c) - 4d can never overflow.
  function automatic int q_int_width(input int data_width);
    return 2 * data_width + 4;
  endfunction

endpackage

// File: rtl/q_fifo.sv
// Small first-word-fall-through result FIFO; rd_data reads 0 while empty.
module q_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_rd = i_rd_en && (r_count != '0);
  assign w_wr = i_wr_en && ((r_count != CW'(DEPTH)) || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end

  assign o_rd_data = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count   = r_count;

endmodule

// File: rtl/q_pipe.sv
// q = ((a-b)*(1+3c) - 4d) >>> SHIFT through S1/S2 registers and an S3 FIFO write.
// Define Q_SAT_EN to clamp the result to OUT_WIDTH and add the sat output.
module q_pipe
  import q_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SHIFT      = DEF_SHIFT,
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH + 3,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  input  logic signed [DATA_WIDTH-1:0] c,
  input  logic signed [DATA_WIDTH-1:0] d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  q,
`ifdef Q_SAT_EN
  output logic                         sat,
`endif
  output logic                         done
);

  localparam int IW = q_int_width(DATA_WIDTH);
  localparam int XW = ((OUT_WIDTH > IW) ? OUT_WIDTH : IW) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef Q_SAT_EN
  localparam int FW = OUT_WIDTH + 1;
`else
  localparam int FW = OUT_WIDTH;
`endif
  localparam logic signed [IW-1:0] ONE_I = IW'(1);

  logic signed [IW-1:0] w_a, w_b, w_c, w_d;
  logic signed [IW-1:0] r_diff, r_tri, r_d4;
  logic signed [IW-1:0] r_prod, r_d4_2;
  logic                 r_v1, r_v2;
  logic signed [IW-1:0] w_res;
  logic signed [XW-1:0] w_res_x;
  logic [OUT_WIDTH-1:0] w_q;
  logic [FW-1:0]        w_wr_data;
  logic [FW-1:0]        w_rd_data;
  logic [CW-1:0]        w_count;
  logic [CW-1:0]        w_occ;
  logic                 w_accept;
  logic                 w_pop;
  q_state_t             r_state;
  q_state_t             w_state_next;

  assign w_a = {{(IW-DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
  assign w_b = {{(IW-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
  assign w_c = {{(IW-DATA_WIDTH){c[DATA_WIDTH-1]}}, c};
  assign w_d = {{(IW-DATA_WIDTH){d[DATA_WIDTH-1]}}, d};

  // Stages never stall: admission is bounded by total occupancy instead.
  assign w_occ    = CW'(r_v1) + CW'(r_v2) + w_count;
  assign in_ready = !rst && (w_occ < CW'(FIFO_DEPTH));
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_diff <= '0;
      r_tri  <= '0;
      r_d4   <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_diff <= w_a - w_b;
        r_tri  <= ONE_I + w_c + (w_c <<< 1);
        r_d4   <= w_d <<< 2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_prod <= '0;
      r_d4_2 <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_prod <= r_diff * r_tri;
        r_d4_2 <= r_d4;
      end
    end
  end

  assign w_res   = (r_prod - r_d4_2) >>> SHIFT;
  assign w_res_x = {{(XW-IW){w_res[IW-1]}}, w_res};

`ifdef Q_SAT_EN
  localparam logic [XW-1:0]        ONE_X   = XW'(1);
  localparam logic signed [XW-1:0] OUT_MAX = signed'((ONE_X << (OUT_WIDTH-1)) - ONE_X);
  localparam logic signed [XW-1:0] OUT_MIN = ~OUT_MAX;

  logic w_sat;

  always_comb begin
    w_sat = 1'b0;
    w_q   = w_res_x[OUT_WIDTH-1:0];
    if (w_res_x > OUT_MAX) begin
      w_sat = 1'b1;
      w_q   = OUT_MAX[OUT_WIDTH-1:0];
    end else if (w_res_x < OUT_MIN) begin
      w_sat = 1'b1;
      w_q   = OUT_MIN[OUT_WIDTH-1:0];
    end
  end

  assign w_wr_data = {w_sat, w_q};
  assign sat       = rst ? 1'b0 : w_rd_data[OUT_WIDTH];
`else
  logic w_unused_hi;

  assign w_q         = w_res_x[OUT_WIDTH-1:0];
  assign w_wr_data   = w_q;
  assign w_unused_hi = ^w_res_x[XW-1:OUT_WIDTH];
`endif

  q_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_v2),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_count   (w_count)
  );

  assign out_valid = !rst && (w_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign q         = rst ? '0 : signed'(w_rd_data[OUT_WIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_RUN;
      ST_RUN:  if (!w_accept && !r_v1 && !r_v2 && (w_count == '0)) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    done = !rst && (r_state == ST_RUN) && (w_state_next == ST_IDLE);
  end

endmodule

// File: tb/tb_q_pipe.sv
// Randomised and directed bench for q_pipe: default-width DUT plus a 20-bit-output twin in lock-step.
module tb_q_pipe;

  localparam int DW  = 16;
  localparam int SH  = 1;
  localparam int OW1 = 2 * DW + 3;
  localparam int OW2 = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, in_valid, out_ready;
  logic signed [DW-1:0]  a, b, c, d;
  logic                  in_ready1, out_valid1, done1;
  logic                  in_ready2, out_valid2, done2;
  logic signed [OW1-1:0] q1;
  logic signed [OW2-1:0] q2;
`ifdef Q_SAT_EN
  logic                  sat1, sat2;
`endif

  q_pipe #(.DATA_WIDTH(DW), .SHIFT(SH), .OUT_WIDTH(OW1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid1), .out_ready(out_ready), .q(q1),
`ifdef Q_SAT_EN
    .sat(sat1),
`endif
    .done(done1)
  );

  q_pipe #(.DATA_WIDTH(DW), .SHIFT(SH), .OUT_WIDTH(OW2), .FIFO_DEPTH(4)) u_dut_ow20 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid2), .out_ready(out_ready), .q(q2),
`ifdef Q_SAT_EN
    .sat(sat2),
`endif
    .done(done2)
  );

  typedef struct {
    logic signed [63:0] q1;
    logic signed [63:0] q2;
    bit                 s1;
    bit                 s2;
  } exp_t;

  exp_t               exp_q[$];
  int                 acc_cyc_log[$];
  int                 pop_cyc_log[$];
  logic signed [63:0] pop_q_log[$];
  logic signed [63:0] pop_q2_log[$];
  bit                 last_sat2;
  int                 n_vec = 0;
  int                 n_err = 0;
  int                 cyc = 0;
  int                 done_cnt = 0;
  int                 last_done_cyc = -1;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then wrap or clamp to the output width.
  function automatic logic signed [63:0] model(input logic signed [DW-1:0] ia, ib, ic, id,
                                               input int ow, output bit s);
    longint ea, eb, ec, ed, e, hi, m;
    ea = ia; eb = ib; ec = ic; ed = id;
    e  = ((ea - eb) * (1 + 3 * ec) - 4 * ed) >>> SH;
    hi = (longint'(1) <<< (ow - 1)) - 1;
    s  = 1'b0;
`ifdef Q_SAT_EN
    m = e;
    if (e > hi) begin
      s = 1'b1;
      m = hi;
    end else if (e < -hi - 1) begin
      s = 1'b1;
      m = -hi - 1;
    end
`else
    m = e & ((longint'(1) <<< ow) - 1);
    if (m > hi) m = m - (longint'(1) <<< ow);
`endif
    return m;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      while (acc_cyc_log.size() > pop_cyc_log.size()) void'(acc_cyc_log.pop_back());
    end else begin
      if (done1) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (in_valid && in_ready1) begin
        e.q1 = model(a, b, c, d, OW1, e.s1);
        e.q2 = model(a, b, c, d, OW2, e.s2);
        exp_q.push_back(e);
        acc_cyc_log.push_back(cyc);
      end
      if (out_valid1 && out_ready) begin
        check("lockstep", {in_ready2, out_valid2, done2}, {in_ready1, out_valid1, done1});
        if (exp_q.size() == 0) begin
          check("spurious_pop", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("q", q1, e.q1);
          check("q_ow20", q2, e.q2);
`ifdef Q_SAT_EN
          check("sat", sat1, e.s1);
          check("sat_ow20", sat2, e.s2);
          last_sat2 = sat2;
`endif
        end
        pop_cyc_log.push_back(cyc);
        pop_q_log.push_back(q1);
        pop_q2_log.push_back(q2);
        $display("pop %0d @cyc %0d: q=%0d q_ow20=%0d", pop_q_log.size(), cyc, q1, q2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic signed [DW-1:0] ia, ib, ic, id);
    bit ok = 1'b0;
    in_valid = 1'b1;
    a = ia; b = ib; c = ic; d = id;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready1;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_pops(input int n);
    for (int i = 0; i < 200 && pop_q_log.size() < n; i++) tick();
    check("pop_wait", pop_q_log.size() >= n, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || out_valid1); i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [DW-1:0] rnd();
    case ($urandom_range(0, 7))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return DW'($urandom_range(0, 15));
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int k0, idx, n_acc, d0;
    logic signed [63:0] held;
    bit held_v;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", in_ready1, 0);
    check("rst_out_valid", out_valid1, 0);
    check("rst_q", q1, 0);
    check("rst_done", done1, 0);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready1, 1);
    check("out_valid_after_rst", out_valid1, 0);
    tick();

    // Single transaction: latency and done pulse
    out_ready = 1'b1;
    d0 = done_cnt;
    k0 = pop_q_log.size();
    offer(10, 5, 2, 3);
    wait_pops(k0 + 1);
    repeat (4) tick();
    check("q_single", pop_q_log[k0], 11);
    check("latency", pop_cyc_log[k0] - acc_cyc_log[k0], 3);
    check("done_once", done_cnt - d0, 1);
    check("done_after_pop", last_done_cyc - pop_cyc_log[k0], 1);

    // Back-to-back pair
    k0 = pop_q_log.size();
    offer(-5, 10, 3, -2);
    offer(16'h8000, 0, 0, 0);
    wait_pops(k0 + 2);
    check("b2b_q0", pop_q_log[k0], -71);
    check("b2b_q1", pop_q_log[k0+1], -16384);
    check("b2b_pop_spacing", pop_cyc_log[k0+1] - pop_cyc_log[k0], 1);
    check("b2b_acc_spacing", acc_cyc_log[k0+1] - acc_cyc_log[k0], 1);

    // Extreme operands on the 20-bit twin
    k0 = pop_q_log.size();
    offer(32767, -32768, 32767, -32768);
    wait_pops(k0 + 1);
    check("extreme_q_full", pop_q_log[k0], 64'sd3221176321);
`ifdef Q_SAT_EN
    check("extreme_q_ow20", pop_q2_log[k0], 524287);
    check("extreme_sat_ow20", last_sat2, 1);
`else
    check("extreme_q_ow20", pop_q2_log[k0], -49151);
`endif
    repeat (3) tick();

    // Stalled consumer: 6 offered, only 4 admitted, q held stable
    out_ready = 1'b0;
    idx = 0;
    held = '0;
    held_v = 1'b0;
    k0 = pop_q_log.size();
    for (int i = 0; i < 10; i++) begin
      in_valid = (idx < 6);
      a = DW'(idx * 1000 - 2500); b = DW'(idx * 37); c = DW'(7 - idx * 3); d = DW'(idx * 11 - 20);
      @(negedge clk);
      if (in_valid && in_ready1) idx++;
      if (out_valid1) begin
        if (held_v) check("q_hold", q1, held);
        held = q1;
        held_v = 1'b1;
      end
      tick();
    end
    check("stall_accepted", idx, 4);
    @(negedge clk);
    check("stall_in_ready", in_ready1, 0);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && idx < 6; i++) begin
      in_valid = 1'b1;
      a = DW'(idx * 1000 - 2500); b = DW'(idx * 37); c = DW'(7 - idx * 3); d = DW'(idx * 11 - 20);
      @(negedge clk);
      if (in_ready1) idx++;
      tick();
    end
    in_valid = 1'b0;
    check("stall_all_accepted", idx, 6);
    wait_pops(k0 + 6);
    drain();

    // Reset with three results in flight
    out_ready = 1'b0;
    offer(rnd(), rnd(), rnd(), rnd());
    offer(rnd(), rnd(), rnd(), rnd());
    offer(rnd(), rnd(), rnd(), rnd());
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid1, 0);
    check("midrst_in_ready", in_ready1, 0);
    check("midrst_q", q1, 0);
    check("midrst_done", done1, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("postrst_out_valid", out_valid1, 0);
    d0 = done_cnt;
    tick();
    out_ready = 1'b1;
    repeat (6) tick();
    check("postrst_no_done", done_cnt - d0, 0);
    k0 = pop_q_log.size();
    offer(7, -3, -4, 100);
    wait_pops(k0 + 1);
    check("postrst_q", pop_q_log[k0], -255);
    drain();

    // Random traffic with a toggling consumer
    n_acc = 0;
    for (int i = 0; i < 20000 && n_acc < 1000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a = rnd(); b = rnd(); c = rnd(); d = rnd();
      out_ready = $urandom_range(0, 1);
      @(negedge clk);
      if (in_valid && in_ready1) n_acc++;
      tick();
    end
    in_valid = 1'b0;
    check("random_accepts", n_acc, 1000);
    drain();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
